// File: rtl/spi_fifo_tx_master_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo_tx_master_if
// Brief    : TX FIFO read port, SPI pins and RX frame strobe for spi_fifo_tx_master.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_fifo_tx_master_if #(
    parameter int FS = 8
);
    logic          enable;
    logic [FS-1:0] fifo_data;
    logic          fifo_flag;
    logic          fifo_empty;
    logic          fifo_read;
    logic          spi_sck;
    logic          spi_ss_n;
    logic          spi_mosi;
    logic          spi_miso;
    logic [FS-1:0] rx_data;
    logic          rx_valid;
    logic          busy;

    modport master (
        input  enable, fifo_data, fifo_flag, fifo_empty, spi_miso,
        output fifo_read, spi_sck, spi_ss_n, spi_mosi, rx_data, rx_valid, busy
    );

    modport slave (
        output enable, fifo_data, fifo_flag, fifo_empty, spi_miso,
        input  fifo_read, spi_sck, spi_ss_n, spi_mosi, rx_data, rx_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_fifo_tx_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_fifo_tx_master
// Brief    : Pops frames from a TX FIFO and shifts them out as SPI mode-0 master,
//            returning each received frame with a 1-cycle valid strobe.
//            Optional macro SPI_TX_FLAG_EOF_EN: FIFO flag bit ends the transfer.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fifo_tx_master #(
    parameter int CFG_FRAME_SIZE = 8,
    parameter int CFG_CLK_DIV    = 2
) (
    input  wire logic             pclk,
    input  wire logic             sreset,
    spi_fifo_tx_master_if.master  bus
);
    localparam int         c_FS       = CFG_FRAME_SIZE;
    localparam int         c_BW       = (c_FS > 1) ? $clog2(c_FS) : 1;
    localparam logic [7:0] c_DIV_LAST = 8'(CFG_CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_FS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;

    logic [2:0]      r_state;
    logic [7:0]      r_div;
    logic [c_BW-1:0] r_bit;
    logic [c_FS-1:0] r_tx;
    logic [c_FS-1:0] r_rx;
    logic [c_FS-1:0] r_rx_data;
    logic            r_rx_valid;
    logic            r_sck;
    logic            r_ss_n;

    logic            w_pop;
    logic            w_eof_stop;
    logic [c_FS-1:0] w_rx_next;

    assign w_pop = !sreset && !bus.fifo_empty &&
                   (((r_state == S_IDLE) && bus.enable) || (r_state == S_FETCH));
    assign w_rx_next = {r_rx[c_FS-2:0], bus.spi_miso};

`ifdef SPI_TX_FLAG_EOF_EN
    logic r_eof;

    always_ff @(posedge pclk) begin
        if (sreset) begin
            r_eof <= 1'b0;
        end else if (w_pop) begin
            r_eof <= bus.fifo_flag;
        end
    end

    assign w_eof_stop = r_eof;
`else
    assign w_eof_stop = 1'b0;
`endif

    // Each bit is a high phase then a low phase; the edge leaving LEAD/FETCH is the first rise.
    always_ff @(posedge pclk) begin
        if (sreset) begin
            r_state    <= S_IDLE;
            r_div      <= 8'd0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_ss_n     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx    <= bus.fifo_data;
                        r_ss_n  <= 1'b0;
                        r_div   <= c_DIV_LAST;
                        r_state <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (r_div == 8'd0) begin
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_div   <= c_DIV_LAST;
                        r_bit   <= c_BIT_LAST;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_div != 8'd0) begin
                        r_div <= r_div - 8'd1;
                    end else begin
                        r_div <= c_DIV_LAST;
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            r_tx  <= {r_tx[c_FS-2:0], 1'b0};
                        end else if (r_bit == '0) begin
                            r_rx_data  <= r_rx;
                            r_rx_valid <= 1'b1;
                            r_state    <= (bus.enable && !bus.fifo_empty && !w_eof_stop)
                                          ? S_FETCH : S_TRAIL;
                        end else begin
                            r_sck <= 1'b1;
                            r_rx  <= w_rx_next;
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_pop) begin
                        r_tx    <= bus.fifo_data;
                        r_sck   <= 1'b1;
                        r_rx    <= w_rx_next;
                        r_div   <= c_DIV_LAST;
                        r_bit   <= c_BIT_LAST;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div   <= c_DIV_LAST;
                        r_state <= S_TRAIL;
                    end
                end
                S_TRAIL: begin
                    if (r_div == 8'd0) begin
                        r_ss_n  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In FETCH the next MSB comes straight from the FIFO head so MOSI settles while SCK is low.
    always_comb begin
        bus.spi_mosi = 1'b0;
        if (r_state == S_FETCH) begin
            bus.spi_mosi = bus.fifo_data[c_FS-1];
        end else if ((r_state == S_LEAD) || (r_state == S_SHIFT)) begin
            bus.spi_mosi = r_tx[c_FS-1];
        end
    end

    assign bus.fifo_read = w_pop;
    assign bus.spi_sck   = r_sck;
    assign bus.spi_ss_n  = r_ss_n;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_fifo_tx_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_fifo_tx_master
// Brief    : Self-checking bench for spi_fifo_tx_master (FS=8, DIV=2) with a FIFO
//            model and an SPI slave-side observer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fifo_tx_master;
    localparam int FS  = 8;
    localparam int DIV = 2;
`ifdef SPI_TX_FLAG_EOF_EN
    localparam bit EOF_EN = 1'b1;
`else
    localparam bit EOF_EN = 1'b0;
`endif

    logic pclk   = 1'b0;
    logic sreset = 1'b1;

    spi_fifo_tx_master_if #(.FS(FS)) bus();

    spi_fifo_tx_master #(
        .CFG_FRAME_SIZE(FS),
        .CFG_CLK_DIV   (DIV)
    ) dut (
        .pclk  (pclk),
        .sreset(sreset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // TX FIFO model: {flag, data} entries, head presented combinationally
    logic [8:0] mem [64];
    int         wp     = 0;
    int         rp     = 0;
    int         n_pops = 0;
    int         n_rxv  = 0;
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];

    logic       tb_miso   = 1'b0;
    int         miso_mode = 0;   // 0 random, 1 tied high, 2 loopback

    assign bus.fifo_empty = (wp == rp);
    assign bus.fifo_data  = mem[6'(rp)][7:0];
    assign bus.fifo_flag  = mem[6'(rp)][8];
    assign bus.spi_miso   = (miso_mode == 2) ? bus.spi_mosi : tb_miso;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (bus.fifo_read) begin
            rp     <= rp + 1;
            n_pops <= n_pops + 1;
        end
        if (bus.rx_valid) n_rxv <= n_rxv + 1;
    end

    task automatic push(input logic [7:0] d, input logic f);
        mem[6'(wp)] = {f, d};
        wp++;
        exp_tx.push_back(d);
    endtask

    function automatic logic next_miso();
        return (miso_mode == 1) ? 1'b1 : 1'($urandom);
    endfunction

    // Slave-side observer: decodes frames and checks SPI timing against the ideal waveform
    bit         mon_en = 1'b0;
    logic       p_sck  = 1'b0;
    logic       p_ss   = 1'b1;
    int         t_ss, t_rise, t_fall;
    int         rif    = 0;
    bit         first  = 1'b1;
    logic [7:0] mo_w, mi_w;
    int         sessions = 0;

    always @(negedge pclk) begin
        if (!mon_en || sreset) begin
            rif = 0;
        end else begin
            if (bus.fifo_read) check_value("pop_when_empty", 32'(bus.fifo_empty), 32'd0);
            if (p_ss && !bus.spi_ss_n) begin
                t_ss    = cyc;
                rif     = 0;
                first   = 1'b1;
                tb_miso = next_miso();
            end
            if (!p_sck && bus.spi_sck) begin
                if (rif != 0)  check_value("sck_period", 32'(cyc - t_rise), 32'(2 * DIV));
                else if (first) check_value("ss_to_first_rise", 32'(cyc - t_ss), 32'(DIV));
                else           check_value("frame_gap", 32'(cyc - t_rise), 32'(2 * DIV + 1));
                t_rise = cyc;
                mo_w   = {mo_w[6:0], bus.spi_mosi};
                mi_w   = {mi_w[6:0], bus.spi_miso};
                rif++;
                if (rif == FS) begin
                    rif   = 0;
                    first = 1'b0;
                    check_value("mosi_frame_expected", 32'(exp_tx.size() > 0), 32'd1);
                    if (exp_tx.size() > 0) check_value("mosi_word", 32'(mo_w), 32'(exp_tx.pop_front()));
                    exp_rx.push_back(mi_w);
                end
            end
            if (p_sck && !bus.spi_sck) begin
                check_value("sck_high_time", 32'(cyc - t_rise), 32'(DIV));
                t_fall  = cyc;
                tb_miso = next_miso();
            end
            if (!p_ss && bus.spi_ss_n) begin
                check_value("trail_time", 32'(cyc - t_fall), 32'(2 * DIV));
                check_value("ss_on_frame_boundary", 32'(rif), 32'd0);
                sessions++;
            end
            if (bus.rx_valid) begin
                check_value("rx_frame_expected", 32'(exp_rx.size() > 0), 32'd1);
                if (exp_rx.size() > 0) check_value("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
            end
        end
        p_sck = bus.spi_sck;
        p_ss  = bus.spi_ss_n;
    end

    task automatic run_until_idle(input bit need_empty);
        int n = 0;
        @(negedge pclk);
        while ((bus.busy || (need_empty && !bus.fifo_empty)) && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        check_value("idle_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(negedge pclk);
    endtask

    task automatic check_burst(input string tag, input int n_words, input int n_sess,
                               input int p0, input int v0, input int s0);
        check_value({tag, "_pops"}, 32'(n_pops - p0), 32'(n_words));
        check_value({tag, "_rxvalid"}, 32'(n_rxv - v0), 32'(n_words));
        check_value({tag, "_sessions"}, 32'(sessions - s0), 32'(n_sess));
    endtask

    initial begin
        int p0, v0, s0, n, es, k;
        logic [7:0] d;
        logic       f, ps;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        bus.enable = 1'b0;
        repeat (2) @(negedge pclk);
        check_value("rst_ss_n", 32'(bus.spi_ss_n), 32'd1);
        check_value("rst_sck", 32'(bus.spi_sck), 32'd0);
        check_value("rst_mosi", 32'(bus.spi_mosi), 32'd0);
        check_value("rst_busy", 32'(bus.busy), 32'd0);
        check_value("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_value("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check_value("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
        sreset = 1'b0;
        mon_en = 1'b1;
        @(negedge pclk);

        // Single frame, MISO tied high
        miso_mode = 1;
        p0 = n_pops; v0 = n_rxv; s0 = sessions;
        push(8'hA5, 1'b0);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;
        check_value("t1_rx_data", 32'(bus.rx_data), 32'hFF);
        check_burst("t1", 1, 1, p0, v0, s0);

        // Two back-to-back frames, one select window
        miso_mode = 0;
        p0 = n_pops; v0 = n_rxv; s0 = sessions;
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b0);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;
        check_burst("t2", 2, 1, p0, v0, s0);

        // Loopback
        miso_mode = 2;
        push(8'h81, 1'b0);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;
        check_value("t3_loopback", 32'(bus.rx_data), 32'h81);
        miso_mode = 0;

        // Flagged frame: ends the transfer only when the EOF option is built in
        p0 = n_pops; v0 = n_rxv; s0 = sessions;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;
        check_burst("t4", 2, EOF_EN ? 2 : 1, p0, v0, s0);

        // enable dropped during the first frame: that frame completes alone
        p0 = n_pops; s0 = sessions;
        push(8'h6E, 1'b0);
        push(8'h97, 1'b0);
        bus.enable = 1'b1;
        k = 0;
        while (!bus.spi_sck && k < 100) begin @(negedge pclk); k++; end
        check_value("en_drop_first_rise", 32'(k < 100), 32'd1);
        bus.enable = 1'b0;
        run_until_idle(1'b0);
        check_value("en_drop_pops", 32'(n_pops - p0), 32'd1);
        check_value("en_drop_sessions", 32'(sessions - s0), 32'd1);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;

        // Random bursts
        for (int b = 0; b < 8; b++) begin
            p0 = n_pops; v0 = n_rxv; s0 = sessions;
            n  = int'($urandom_range(5, 1));
            es = 1;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                f = 1'($urandom);
                push(d, f);
                if (EOF_EN && f && i < n - 1) es++;
            end
            bus.enable = 1'b1;
            run_until_idle(1'b1);
            bus.enable = 1'b0;
            check_burst("rnd", n, es, p0, v0, s0);
        end

        // enable low with data waiting: nothing happens
        p0 = n_pops;
        push(8'h5A, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk);
            check_value("dis_fifo_read", 32'(bus.fifo_read), 32'd0);
        end
        check_value("dis_busy", 32'(bus.busy), 32'd0);
        check_value("dis_ss_n", 32'(bus.spi_ss_n), 32'd1);
        bus.enable = 1'b1;
        run_until_idle(1'b1);
        bus.enable = 1'b0;
        check_value("dis_then_en_pops", 32'(n_pops - p0), 32'd1);
        check_value("all_tx_frames_seen", 32'(exp_tx.size()), 32'd0);
        check_value("all_rx_frames_seen", 32'(exp_rx.size()), 32'd0);

        // Reset in the middle of a frame
        mon_en = 1'b0;
        p0 = n_pops; v0 = n_rxv;
        push(8'hE7, 1'b0);
        bus.enable = 1'b1;
        k = 0; n = 0; ps = bus.spi_sck;
        while (n < 4 && k < 200) begin
            @(negedge pclk);
            if (bus.spi_sck && !ps) n++;
            ps = bus.spi_sck;
            k++;
        end
        check_value("mid_reset_reach_bit4", 32'(n), 32'd4);
        sreset = 1'b1;
        @(negedge pclk);
        check_value("mid_reset_ss_n", 32'(bus.spi_ss_n), 32'd1);
        check_value("mid_reset_sck", 32'(bus.spi_sck), 32'd0);
        check_value("mid_reset_mosi", 32'(bus.spi_mosi), 32'd0);
        check_value("mid_reset_busy", 32'(bus.busy), 32'd0);
        check_value("mid_reset_fifo_read", 32'(bus.fifo_read), 32'd0);
        sreset = 1'b0;
        repeat (40) @(negedge pclk);
        check_value("mid_reset_pops", 32'(n_pops - p0), 32'd1);
        check_value("mid_reset_no_rx_valid", 32'(n_rxv - v0), 32'd0);
        check_value("mid_reset_rx_data", 32'(bus.rx_data), 32'd0);
        check_value("mid_reset_idle", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
